// File: rtl/pipe_pkg.sv
// Shared constants for the elastic pipeline-stage register: state encodings and the ISA NOP word.
package pipe_pkg;

    localparam logic [1:0] PS_EMPTY = 2'd0;
    localparam logic [1:0] PS_ONE   = 2'd1;
    localparam logic [1:0] PS_FULL  = 2'd2;

    // Encoded NOP instruction; parents pass this as NOP_VALUE.
    localparam logic [15:0] ISA_NOP = 16'h0800;

    function automatic logic ps_can_accept(input logic [1:0] state);
        return state != PS_FULL;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One holding register for a pipeline entry: payload, error bit and valid flag.
module pipe_slot #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic             valid,
    input  logic [WIDTH-1:0] data,
    input  logic             err,
    output logic             held_valid,
    output logic [WIDTH-1:0] held_data,
    output logic             held_err
);

    always_ff @(posedge clk) begin
        if (clear) begin
            held_valid <= 1'b0;
            held_data  <= '0;
            held_err   <= 1'b0;
        end else if (load) begin
            held_valid <= valid;
            held_data  <= data;
            held_err   <= err;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline-stage register with flush, error tagging and protocol checker.
// Define PIPE_SKID_EN for the 2-entry skid build with registered in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] NOP_VALUE   = {WIDTH{1'b0}},
    parameter bit               CHECK_PROTO = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_err,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    output logic             proto_err
);

    logic             accept;
    logic             retire;
    logic             clear;
    logic             live;
    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic             head_valid;
    logic [WIDTH-1:0] head_data;
    logic             head_err;
    logic             head_load;
    logic             head_vin;
    logic [WIDTH-1:0] head_din;
    logic             head_ein;

    assign clear  = rst | flush;
    assign accept = in_valid & in_ready & ~flush;
    assign retire = out_valid & out_ready;
    assign live   = head_valid & ~rst;

    pipe_slot #(.WIDTH(WIDTH)) u_head (
        .clk        (clk),
        .clear      (clear),
        .load       (head_load),
        .valid      (head_vin),
        .data       (head_din),
        .err        (head_ein),
        .held_valid (head_valid),
        .held_data  (head_data),
        .held_err   (head_err)
    );

`ifdef PIPE_SKID_EN
    logic             rdy_q;
    logic             skid_load;
    logic             skid_vin;
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             skid_err;

    pipe_slot #(.WIDTH(WIDTH)) u_skid (
        .clk        (clk),
        .clear      (clear),
        .load       (skid_load),
        .valid      (skid_vin),
        .data       (in_data),
        .err        (in_err),
        .held_valid (skid_valid),
        .held_data  (skid_data),
        .held_err   (skid_err)
    );

    always_comb begin
        state_nx  = state;
        head_load = 1'b0;
        head_vin  = 1'b1;
        head_din  = in_data;
        head_ein  = in_err;
        skid_load = 1'b0;
        skid_vin  = 1'b1;
        case (state)
            PS_EMPTY: begin
                if (accept) begin
                    state_nx  = PS_ONE;
                    head_load = 1'b1;
                end
            end
            PS_ONE: begin
                if (accept && !retire) begin
                    state_nx  = PS_FULL;
                    skid_load = 1'b1;
                end else if (accept) begin
                    head_load = 1'b1;
                end else if (retire) begin
                    state_nx  = PS_EMPTY;
                    head_load = 1'b1;
                    head_vin  = 1'b0;
                end
            end
            PS_FULL: begin
                if (retire) begin
                    state_nx  = PS_ONE;
                    head_load = 1'b1;
                    head_vin  = skid_valid;
                    head_din  = skid_data;
                    head_ein  = skid_err;
                    skid_load = 1'b1;
                    skid_vin  = 1'b0;
                end
            end
            default: state_nx = PS_EMPTY;
        endcase
    end

    // Ready is precomputed from the next state so it never sees out_ready combinationally.
    always_ff @(posedge clk) begin
        if (clear) rdy_q <= 1'b1;
        else       rdy_q <= ps_can_accept(state_nx);
    end

    assign in_ready = rdy_q & ~rst;
`else
    always_comb begin
        state_nx  = state;
        head_load = 1'b0;
        head_vin  = 1'b1;
        head_din  = in_data;
        head_ein  = in_err;
        if (accept) begin
            state_nx  = PS_ONE;
            head_load = 1'b1;
        end else if (retire) begin
            state_nx  = PS_EMPTY;
            head_load = 1'b1;
            head_vin  = 1'b0;
        end
    end

    assign in_ready = ~rst & (~out_valid | out_ready);
`endif

    always_ff @(posedge clk) begin
        if (clear) state <= PS_EMPTY;
        else       state <= state_nx;
    end

    assign out_valid = live;
    assign out_data  = live ? head_data : NOP_VALUE;
    assign out_err   = live & head_err;

    generate
        if (CHECK_PROTO) begin : g_proto
            logic             stalled;
            logic [WIDTH:0]   held;
            logic             sticky;
            logic             trig;

            // A stalled offer must stay valid and unchanged unless a flush squashes it.
            always_comb begin
                trig = $isunknown(in_valid) |
                       (stalled & ~flush & (~in_valid | ({in_err, in_data} != held)));
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    stalled <= 1'b0;
                    held    <= '0;
                    sticky  <= 1'b0;
                end else begin
                    stalled <= in_valid & ~in_ready & ~flush;
                    held    <= {in_err, in_data};
                    if (trig) sticky <= 1'b1;
                end
            end

            assign proto_err = sticky & ~rst;
        end else begin : g_no_proto
            assign proto_err = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (WIDTH=16, NOP 16'h0800); follows PIPE_SKID_EN.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_err;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_err;
    logic        proto_err;

    int checks = 0;
    int errors = 0;

    pipe_stage_reg #(
        .WIDTH       (16),
        .NOP_VALUE   (ISA_NOP),
        .CHECK_PROTO (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_err    (in_err),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] errpat;
        errpat = 8'b0001_0010;

        rst = 1'b1; in_valid = 1'b1; in_data = 16'h1234; in_err = 1'b0;
        flush = 1'b0; out_ready = 1'b1;

        // Reset
        tick(); tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {16'd0, out_data}, 32'h0800);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        chk("rst_proto_err", {31'd0, proto_err}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("idle_out_valid", {31'd0, out_valid}, 32'd0);

        // Streaming
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 16'hA000 + 16'(i);
            in_err   = errpat[i];
            #1;
            chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
            tick();
            chk("stream_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stream_out_data", {16'd0, out_data}, {16'd0, 16'hA000 + 16'(i)});
            chk("stream_out_err", {31'd0, out_err}, {31'd0, errpat[i]});
        end
        in_valid = 1'b0; in_err = 1'b0;
        tick();
        chk("stream_drain_valid", {31'd0, out_valid}, 32'd0);
        chk("stream_drain_data", {16'd0, out_data}, 32'h0800);

        // Back-pressure
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'hB001;
        #1;
        chk("bp_rdy0", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bp_head0", {16'd0, out_data}, 32'hB001);
        in_data = 16'hB002;
        #1;
`ifdef PIPE_SKID_EN
        chk("bp_rdy1", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bp_rdy_fall", {31'd0, in_ready}, 32'd0);
        chk("bp_hold1", {16'd0, out_data}, 32'hB001);
        in_data = 16'hB003;
        tick();
        chk("bp_hold2", {16'd0, out_data}, 32'hB001);
        chk("bp_rdy_low", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        tick();
        chk("bp_out1", {16'd0, out_data}, 32'hB002);
        chk("bp_rdy_back", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bp_out2", {16'd0, out_data}, 32'hB003);
`else
        chk("bp_rdy_comb0", {31'd0, in_ready}, 32'd0);
        tick();
        chk("bp_hold1", {16'd0, out_data}, 32'hB001);
        chk("bp_hold1_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_rdy_comb1", {31'd0, in_ready}, 32'd0);
        tick();
        chk("bp_hold2", {16'd0, out_data}, 32'hB001);
        out_ready = 1'b1;
        #1;
        chk("bp_rdy_comb2", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bp_out1", {16'd0, out_data}, 32'hB002);
        in_data = 16'hB003;
        tick();
        chk("bp_out2", {16'd0, out_data}, 32'hB003);
`endif
        in_valid = 1'b0;
        tick();
        chk("bp_drain_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_proto_clean", {31'd0, proto_err}, 32'd0);

        // Flush with an offered entry in the same cycle
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'hC001; in_err = 1'b1;
        tick();
        in_data = 16'hC002; in_err = 1'b0;
        tick();
        chk("fl_head", {16'd0, out_data}, 32'hC001);
        chk("fl_head_err", {31'd0, out_err}, 32'd1);
        flush = 1'b1; in_data = 16'hC003;
        tick();
        chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_out_data", {16'd0, out_data}, 32'h0800);
        chk("fl_out_err", {31'd0, out_err}, 32'd0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("fl_no_c003", {16'd0, out_data}, 32'h0800);
        tick();
        chk("fl_still_empty", {31'd0, out_valid}, 32'd0);
        chk("fl_proto_clean", {31'd0, proto_err}, 32'd0);

        // Protocol violation: stalled offer changes payload
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'hD000;
        tick();
`ifdef PIPE_SKID_EN
        in_data = 16'hD00F;
        tick();
`endif
        in_data = 16'hD001;
        #1;
        chk("pr_stalled", {31'd0, in_ready}, 32'd0);
        tick();
        chk("pr_before", {31'd0, proto_err}, 32'd0);
        in_data = 16'hD002;
        tick();
        chk("pr_set", {31'd0, proto_err}, 32'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick(); tick();
        chk("pr_sticky", {31'd0, proto_err}, 32'd1);
        rst = 1'b1;
        #1;
        chk("pr_rst_mask", {31'd0, proto_err}, 32'd0);
        chk("pr_rst_ready", {31'd0, in_ready}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("pr_cleared", {31'd0, proto_err}, 32'd0);
        chk("pr_empty", {31'd0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
